// File: rtl/cc_pkg.sv
// Shared types and constants for the condition-code / branch-enable unit.
package cc_pkg;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N     = 3'b100;
    localparam nzp_t NZP_Z     = 3'b010;
    localparam nzp_t NZP_P     = 3'b001;
    localparam nzp_t NZP_RESET = NZP_Z;

    // Width-independent CC decode: the caller reduces the bus to a zero flag
    // and its sign bit, so one function serves every DATA_W.
    function automatic nzp_t calc_nzp(input logic is_zero, input logic sign);
        nzp_t v;
        if (is_zero)   v = NZP_Z;
        else if (sign) v = NZP_N;
        else           v = NZP_P;
        return v;
    endfunction

endpackage

// File: rtl/cc_lifo.sv
// DEPTH x 3-bit stack of saved condition codes with occupancy count and
// sticky overflow/underflow flags. Push+Pop together is a no-op.
module cc_lifo
    import cc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [2:0]       i_din,
    output logic [2:0]       o_top,
    output logic             o_pop_ok,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_err_ovf,
    output logic             o_err_unf
);

    // Address width; storage is rounded up to a power of two so a truncated
    // count always indexes a real entry.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]       r_mem [0:(1<<AW)-1];
    logic [CNT_W-1:0] r_count;
    logic             r_err_ovf;
    logic             r_err_unf;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_ovf;
    logic             w_unf;
    logic [CNT_W-1:0] w_cnt_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);

    // Simultaneous push and pop cancel out: neither legal nor an error.
    assign w_push_ok = i_push & ~i_pop & ~o_full;
    assign w_pop_ok  = i_pop & ~i_push & ~o_empty;
    assign w_ovf     = i_push & ~i_pop & o_full;
    assign w_unf     = i_pop & ~i_push & o_empty;

    assign w_cnt_m1 = r_count - CNT_W'(1);
    assign w_wr_idx = r_count[AW-1:0];
    assign w_rd_idx = w_cnt_m1[AW-1:0];

    assign o_top     = r_mem[w_rd_idx];
    assign o_pop_ok  = w_pop_ok;
    assign o_count   = r_count;
    assign o_err_ovf = r_err_ovf;
    assign o_err_unf = r_err_unf;

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge Clk) begin
        if (!Reset && w_push_ok) r_mem[w_wr_idx] <= i_din;
    end

    // Occupancy count and sticky error flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count   <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_push_ok)     r_count <= r_count + CNT_W'(1);
            else if (w_pop_ok) r_count <= w_cnt_m1;
            if (w_ovf) r_err_ovf <= 1'b1;
            if (w_unf) r_err_unf <= 1'b1;
        end
    end

endmodule

// File: rtl/cc_ben_unit.sv
// LC-3 condition-code and branch-enable unit with a LIFO of saved NZP
// values for the interrupt/RTI path.
module cc_ben_unit
    import cc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_CC,
    input  logic [DATA_W-1:0] bus,
    input  logic              LD_BEN,
    input  logic [2:0]        ir_nzp,
    input  logic              Push,
    input  logic              Pop,
    output logic [2:0]        NZP,
    output logic              BEN,
    output logic [CNT_W-1:0]  cc_count,
    output logic              cc_full,
    output logic              cc_empty,
    output logic              err_ovf,
    output logic              err_unf
);

    nzp_t r_nzp;
    logic r_ben;
    nzp_t w_calc;
    nzp_t w_top;
    logic w_pop_ok;

    assign w_calc = calc_nzp(bus == '0, bus[DATA_W-1]);

    // The stack always saves the pre-edge NZP, so Push+LD_CC keeps the old value.
    cc_lifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_push    (Push),
        .i_pop     (Pop),
        .i_din     (r_nzp),
        .o_top     (w_top),
        .o_pop_ok  (w_pop_ok),
        .o_count   (cc_count),
        .o_full    (cc_full),
        .o_empty   (cc_empty),
        .o_err_ovf (err_ovf),
        .o_err_unf (err_unf)
    );

    // NZP register: a legal restore beats a bus load, otherwise hold.
    always_ff @(posedge Clk) begin
        if (Reset)         r_nzp <= NZP_RESET;
        else if (w_pop_ok) r_nzp <= w_top;
        else if (LD_CC)    r_nzp <= w_calc;
    end

    // BEN samples the NZP value registered before this edge.
    always_ff @(posedge Clk) begin
        if (Reset)       r_ben <= 1'b0;
        else if (LD_BEN) r_ben <= |(ir_nzp & r_nzp);
    end

    assign NZP = r_nzp;
    assign BEN = r_ben;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Directed bench for cc_ben_unit (DATA_W=16, DEPTH=4).
module tb_cc_ben_unit;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              LD_CC = 1'b0;
    logic [DATA_W-1:0] bus = '0;
    logic              LD_BEN = 1'b0;
    logic [2:0]        ir_nzp = '0;
    logic              Push = 1'b0;
    logic              Pop = 1'b0;
    logic [2:0]        NZP;
    logic              BEN;
    logic [CNT_W-1:0]  cc_count;
    logic              cc_full;
    logic              cc_empty;
    logic              err_ovf;
    logic              err_unf;

    int n_tests = 0;
    int n_fail  = 0;

    cc_ben_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .bus(bus), .LD_BEN(LD_BEN),
        .ir_nzp(ir_nzp), .Push(Push), .Pop(Pop), .NZP(NZP), .BEN(BEN),
        .cc_count(cc_count), .cc_full(cc_full), .cc_empty(cc_empty),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, then release all strobes.
    task automatic cyc(input logic rst, input logic ldcc, input logic [DATA_W-1:0] b,
                       input logic ldben, input logic [2:0] ir,
                       input logic psh, input logic pp);
        Reset = rst; LD_CC = ldcc; bus = b; LD_BEN = ldben; ir_nzp = ir;
        Push = psh; Pop = pp;
        @(posedge Clk); #1;
        Reset = 0; LD_CC = 0; LD_BEN = 0; Push = 0; Pop = 0;
    endtask

    initial begin
        // reset
        cyc(1, 0, '0, 0, 3'b000, 0, 0);
        chk("rst_nzp", NZP, 3'b010);
        chk("rst_ben", BEN, 0);
        chk("rst_cnt", cc_count, 0);
        chk("rst_empty", cc_empty, 1);
        chk("rst_full", cc_full, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_unf", err_unf, 0);

        // CC decode
        cyc(0, 1, 16'h8000, 0, 3'b000, 0, 0);
        chk("cc_neg", NZP, 3'b100);
        cyc(0, 1, 16'h0000, 0, 3'b000, 0, 0);
        chk("cc_zero", NZP, 3'b010);
        cyc(0, 1, 16'h7FFF, 0, 3'b000, 0, 0);
        chk("cc_pos", NZP, 3'b001);
        cyc(0, 0, 16'h8000, 0, 3'b000, 0, 0);
        chk("cc_hold", NZP, 3'b001);

        // BEN uses pre-edge NZP (001 & 011 -> 1) while NZP updates to 100
        cyc(0, 1, 16'hFFFF, 1, 3'b011, 0, 0);
        chk("ben_old", BEN, 1);
        chk("ben_nzp", NZP, 3'b100);
        cyc(0, 0, '0, 1, 3'b011, 0, 0);
        chk("ben_zero", BEN, 0);
        cyc(0, 0, '0, 0, 3'b100, 0, 0);
        chk("ben_hold", BEN, 0);

        // stack save/restore: entries [100, 001]
        cyc(0, 0, '0, 0, 3'b000, 1, 0);
        chk("push1_cnt", cc_count, 1);
        cyc(0, 1, 16'h0001, 0, 3'b000, 0, 0);
        chk("ld_pos", NZP, 3'b001);
        cyc(0, 1, 16'h0000, 0, 3'b000, 1, 0);
        chk("push2_cnt", cc_count, 2);
        chk("push2_nzp", NZP, 3'b010);
        cyc(0, 0, '0, 0, 3'b000, 0, 1);
        chk("pop1_nzp", NZP, 3'b001);
        chk("pop1_cnt", cc_count, 1);
        cyc(0, 1, 16'h0000, 0, 3'b000, 0, 1);
        chk("pop2_nzp", NZP, 3'b100);
        chk("pop2_cnt", cc_count, 0);
        chk("pop2_empty", cc_empty, 1);

        // underflow: NZP holds
        cyc(0, 0, '0, 0, 3'b000, 0, 1);
        chk("unf_flag", err_unf, 1);
        chk("unf_nzp", NZP, 3'b100);
        chk("unf_cnt", cc_count, 0);

        // overflow
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 3'b000, 1, 0);
        chk("fill_cnt", cc_count, 4);
        chk("fill_full", cc_full, 1);
        chk("fill_ovf", err_ovf, 0);
        cyc(0, 0, '0, 0, 3'b000, 1, 0);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_cnt", cc_count, 4);

        cyc(0, 0, '0, 0, 3'b000, 0, 1);
        chk("pop_full_cnt", cc_count, 3);
        chk("pop_full_nzp", NZP, 3'b100);

        // Push+Pop: no-op on stack, NZP follows LD_CC
        cyc(0, 1, 16'h0001, 0, 3'b000, 1, 1);
        chk("pp_cnt", cc_count, 3);
        chk("pp_nzp", NZP, 3'b001);
        chk("pp_ovf", err_ovf, 1);
        chk("pp_unf", err_unf, 1);

        // make BEN=1 before reset
        cyc(0, 0, '0, 1, 3'b001, 0, 0);
        chk("ben_set", BEN, 1);

        // reset overrides Push/LD_CC/LD_BEN
        cyc(1, 1, 16'h8000, 1, 3'b111, 1, 0);
        chk("rst2_cnt", cc_count, 0);
        chk("rst2_ovf", err_ovf, 0);
        chk("rst2_unf", err_unf, 0);
        chk("rst2_nzp", NZP, 3'b010);
        chk("rst2_ben", BEN, 0);

        // Push+Pop on empty is not an underflow
        cyc(0, 0, '0, 0, 3'b000, 1, 1);
        chk("pp_empty_unf", err_unf, 0);
        chk("pp_empty_cnt", cc_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
